// File: rtl/rgb_pkg.sv
// Shared RGB types used by the PWM block, the encoder top level and the mixer top.
package rgb_pkg;
    localparam int DUTY_W = 8;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef struct packed {
        duty_t r;
        duty_t g;
        duty_t b;
    } rgb_t;
endpackage

// File: rtl/rgb_pwm_if.sv
// Duty inputs from the encoders and the LED drive outputs of rgb_pwm.
interface rgb_pwm_if;
    import rgb_pkg::*;

    logic  en;
    duty_t duty_r;
    duty_t duty_g;
    duty_t duty_b;
    logic  pwm_r;
    logic  pwm_g;
    logic  pwm_b;
    logic  frame_start;

    modport master (
        output en, duty_r, duty_g, duty_b,
        input  pwm_r, pwm_g, pwm_b, frame_start
    );

    modport slave (
        input  en, duty_r, duty_g, duty_b,
        output pwm_r, pwm_g, pwm_b, frame_start
    );
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: frame-boundary shadow of the duty, compare against the shared phase,
// and the registered, polarity-adjusted LED drive.
module pwm_channel
    import rgb_pkg::*;
#(
    parameter bit INVERT = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  load,
    input  duty_t phase_next,
    input  duty_t duty,
    output logic  pwm
);
    duty_t sh;
    duty_t sh_next;
    logic  active;

    assign sh_next = load ? duty : sh;
    // Full scale has to stay on across the wrap, which a plain compare cannot express.
    assign active  = (phase_next < sh_next) | (sh_next == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sh  <= '0;
            pwm <= INVERT;
        end else begin
            sh  <= sh_next;
            pwm <= en ? (INVERT ^ active) : INVERT;
        end
    end
endmodule

// File: rtl/rgb_pwm.sv
// Three-channel left-aligned RGB PWM: shared prescaler and phase counter,
// duties latched per channel only at frame boundaries.
module rgb_pwm
    import rgb_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter bit INVERT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    rgb_pwm_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;
    duty_t         phase;
    duty_t         phase_next;
    logic          tick;
    logic          wrap;

    assign tick       = bus.en && (pre_cnt == PRE_MAX);
    assign wrap       = tick && (phase == '1);
    assign phase_next = tick ? phase + 1'b1 : phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt         <= '0;
            phase           <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            if (bus.en)
                pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            phase           <= phase_next;
            bus.frame_start <= wrap;
        end
    end

    rgb_t                    duty_in;
    logic [2:0][DUTY_W-1:0]  duty_v;
    logic [2:0]              pwm_v;

    assign duty_in = '{r: bus.duty_r, g: bus.duty_g, b: bus.duty_b};
    assign duty_v  = duty_in;

    // Index 2 is red, 0 is blue, following the struct field order.
    for (genvar i = 0; i < 3; i++) begin : g_ch
        pwm_channel #(.INVERT(INVERT)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (bus.en),
            .load       (wrap),
            .phase_next (phase_next),
            .duty       (duty_v[i]),
            .pwm        (pwm_v[i])
        );
    end

    assign bus.pwm_r = pwm_v[2];
    assign bus.pwm_g = pwm_v[1];
    assign bus.pwm_b = pwm_v[0];
endmodule

// File: tb/tb_rgb_pwm.sv
// Directed bench for rgb_pwm: three instances (PRESCALE 1, PRESCALE 4, inverted).
module tb_rgb_pwm;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic [7:0] r1 = '0, g1 = '0, b1 = '0, r4 = '0, ri = '0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rgb_pwm_if bus1();
    rgb_pwm_if bus4();
    rgb_pwm_if busi();

    assign bus1.en = en;  assign bus1.duty_r = r1; assign bus1.duty_g = g1;    assign bus1.duty_b = b1;
    assign bus4.en = en;  assign bus4.duty_r = r4; assign bus4.duty_g = 8'd0;  assign bus4.duty_b = 8'd0;
    assign busi.en = en;  assign busi.duty_r = ri; assign busi.duty_g = 8'd0;  assign busi.duty_b = 8'd0;

    rgb_pwm #(.PRESCALE(1), .INVERT(1'b0)) d1 (.clk(clk), .rst(rst), .bus(bus1));
    rgb_pwm #(.PRESCALE(4), .INVERT(1'b0)) d4 (.clk(clk), .rst(rst), .bus(bus4));
    rgb_pwm #(.PRESCALE(1), .INVERT(1'b1)) di (.clk(clk), .rst(rst), .bus(busi));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int hi, fsn;
        r1 = 8'd64; g1 = 8'd0; b1 = 8'd255; ri = 8'd64; r4 = 8'd10; en = 1'b1;
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if ({bus1.pwm_r, bus1.pwm_g, bus1.pwm_b} !== 3'b000) begin
            failures++; $display("FAIL reset_pwm got=%b want=000", {bus1.pwm_r, bus1.pwm_g, bus1.pwm_b});
        end
        checks++;
        if (bus1.frame_start !== 1'b0) begin
            failures++; $display("FAIL reset_fs got=%b want=0", bus1.frame_start);
        end
        checks++;
        if (busi.pwm_r !== 1'b1) begin
            failures++; $display("FAIL reset_inv_pwm got=%b want=1", busi.pwm_r);
        end
        hi = 0; fsn = 0;
        for (int i = 0; i < 255; i++) begin
            step();
            hi  += int'(bus1.pwm_r) + int'(bus1.pwm_g) + int'(bus1.pwm_b);
            fsn += int'(bus1.frame_start);
        end
        checks++;
        if (hi !== 0 || fsn !== 0) begin
            failures++; $display("FAIL first_frame_quiet highs=%0d fs=%0d want 0 0", hi, fsn);
        end
        step();
        checks++;
        if ({bus1.frame_start, bus1.pwm_r, bus1.pwm_g, bus1.pwm_b} !== 4'b1101) begin
            failures++; $display("FAIL first_boundary got=%b want=1101",
                                 {bus1.frame_start, bus1.pwm_r, bus1.pwm_g, bus1.pwm_b});
        end
    endtask

    task automatic test_steady();
        int rh, rfirst, gh, bh, fsn, dil;
        for (int f = 0; f < 2; f++) begin
            rh = 0; rfirst = 0; gh = 0; bh = 0; fsn = 0; dil = 0;
            for (int i = 0; i < 256; i++) begin
                rh  += int'(bus1.pwm_r);
                if (i < 64) rfirst += int'(bus1.pwm_r);
                gh  += int'(bus1.pwm_g);
                bh  += int'(bus1.pwm_b);
                fsn += int'(bus1.frame_start);
                dil += int'(!busi.pwm_r);
                step();
            end
            checks++;
            if (rh !== 64 || rfirst !== 64) begin
                failures++; $display("FAIL steady_r highs=%0d lead=%0d want 64 64", rh, rfirst);
            end
            checks++;
            if (gh !== 0 || bh !== 256) begin
                failures++; $display("FAIL steady_gb g=%0d b=%0d want 0 256", gh, bh);
            end
            checks++;
            if (fsn !== 1 || bus1.frame_start !== 1'b1) begin
                failures++; $display("FAIL steady_fs count=%0d next=%b want 1 1", fsn, bus1.frame_start);
            end
            checks++;
            if (dil !== 64) begin
                failures++; $display("FAIL steady_inv_active lows=%0d want 64", dil);
            end
        end
    endtask

    task automatic test_midframe_change();
        int rh;
        rh = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 100) r1 = 8'd200;
            rh += int'(bus1.pwm_r);
            step();
        end
        checks++;
        if (rh !== 64 || bus1.frame_start !== 1'b1) begin
            failures++; $display("FAIL mid_change_old highs=%0d fs=%b want 64 1", rh, bus1.frame_start);
        end
        rh = 0;
        for (int i = 0; i < 256; i++) begin
            rh += int'(bus1.pwm_r);
            step();
        end
        checks++;
        if (rh !== 200) begin
            failures++; $display("FAIL mid_change_new highs=%0d want 200", rh);
        end
    endtask

    task automatic test_enable();
        int hi, dis_hi, spacing;
        r1 = 8'd128;
        for (int i = 0; i < 256; i++) step();
        checks++;
        if (bus1.frame_start !== 1'b1) begin
            failures++; $display("FAIL en_setup_fs got=%b want=1", bus1.frame_start);
        end
        hi = 0; dis_hi = 0; spacing = -1;
        for (int k = 0; k < 400; k++) begin
            hi += int'(bus1.pwm_r);
            if (k >= 51 && k <= 87) dis_hi += int'(bus1.pwm_r) + int'(bus1.frame_start);
            if (k == 87) begin
                checks++;
                if (d1.phase !== 8'd50) begin
                    failures++; $display("FAIL en_phase_hold got=%0d want=50", d1.phase);
                end
            end
            en = !(k >= 50 && k <= 86);
            step();
            if (bus1.frame_start) begin
                spacing = k + 1;
                break;
            end
        end
        en = 1'b1;
        checks++;
        if (spacing !== 293) begin
            failures++; $display("FAIL en_spacing got=%0d want=293", spacing);
        end
        checks++;
        if (hi !== 128) begin
            failures++; $display("FAIL en_highs got=%0d want=128", hi);
        end
        checks++;
        if (dis_hi !== 0) begin
            failures++; $display("FAIL en_disabled_quiet got=%0d want=0", dis_hi);
        end
    endtask

    task automatic test_invert_reset();
        int lo, fsn;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (busi.pwm_r !== 1'b0) begin
            failures++; $display("FAIL inv_active got=%b want=0", busi.pwm_r);
        end
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if ({busi.pwm_r, busi.frame_start} !== 2'b10) begin
            failures++; $display("FAIL inv_midreset got=%b want=10", {busi.pwm_r, busi.frame_start});
        end
        lo = 0; fsn = 0;
        for (int i = 0; i < 255; i++) begin
            step();
            lo  += int'(!busi.pwm_r);
            fsn += int'(busi.frame_start);
        end
        checks++;
        if (lo !== 0 || fsn !== 0) begin
            failures++; $display("FAIL inv_first_frame lows=%0d fs=%0d want 0 0", lo, fsn);
        end
        step();
        checks++;
        if ({busi.frame_start, busi.pwm_r} !== 2'b10) begin
            failures++; $display("FAIL inv_boundary got=%b want=10", {busi.frame_start, busi.pwm_r});
        end
    endtask

    task automatic test_prescale4();
        int n, hi, rises;
        logic prev;
        rst = 1'b1; step(); rst = 1'b0;
        n = 0;
        while (n < 1500) begin
            step(); n++;
            if (bus4.frame_start) break;
        end
        checks++;
        if (n !== 1024) begin
            failures++; $display("FAIL ps4_first_fs got=%0d want=1024", n);
        end
        n = 0; hi = 0; rises = 0; prev = 1'b0;
        while (n < 1500) begin
            hi += int'(bus4.pwm_r);
            if (bus4.pwm_r && !prev) rises++;
            prev = bus4.pwm_r;
            step(); n++;
            if (bus4.frame_start) break;
        end
        checks++;
        if (n !== 1024) begin
            failures++; $display("FAIL ps4_period got=%0d want=1024", n);
        end
        checks++;
        if (hi !== 40 || rises !== 1) begin
            failures++; $display("FAIL ps4_pulse highs=%0d runs=%0d want 40 1", hi, rises);
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_midframe_change();
        test_enable();
        test_invert_reset();
        test_prescale4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rgb_pwm.md
Name: rgb_pwm

Overview:
- Three-channel PWM generator driving the RGB LED pins.
- Sits directly downstream of the per-channel rotary encoders: each encoder's 8-bit count is a duty input.
- Duty values are captured into shadow registers only at frame boundaries. Encoder turns mid-frame therefore never produce glitched or truncated pulses.

Parameters:
- PRESCALE, 4: clk cycles per PWM tick. Legal range is 1 or greater.
- INVERT, 0: output polarity. 0 = active-high (common-cathode); 1 = active-low (common-anode).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  run enable
- duty_r  input  8  red duty from encoder count
- duty_g  input  8  green duty
- duty_b  input  8  blue duty
- pwm_r  output  1  red LED drive
- pwm_g  output  1  green LED drive
- pwm_b  output  1  blue LED drive
- frame_start  output  1  one-clk strobe, first cycle of each frame

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates only on posedge clk.
- Reset applies on the first edge with rst high. After that edge:
  - pre_cnt = 0, phase = 0
  - shadows sh_r/g/b = 0
  - pwm_r/g/b = INVERT (inactive level)
  - frame_start = 0
- Reset mid-frame aborts the frame immediately, with no completion.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 while en = 1.
  - tick is high when en = 1 and pre_cnt == PRESCALE-1; pre_cnt wraps to 0 on the tick.
  - PRESCALE = 1 gives a tick every enabled cycle.
- Phase counter:
  - 8-bit phase increments on each tick and wraps 255 -> 0.
  - One frame = 256 ticks = 256*PRESCALE clk cycles while enabled.
- Shadow load:
  - On the tick where phase goes 255 -> 0, sh_x <= duty_x for all three channels in the same edge.
  - At all other times the shadows hold.
  - duty_x changes mid-frame have no effect until the next boundary.
- frame_start is registered and high exactly one clk cycle: the first cycle phase == 0 after a wrap.
  - It is not asserted for the phase = 0 state following reset.
- Output, from next-state values: pwm_x <= (INVERT ^ ((phase_next < sh_next) | (sh_next == 255))) when en = 1.
  - pwm_x is therefore aligned with the phase and shadow it reflects; there is no extra latency cycle.
  - duty 0: never active.
  - duty N (1..254): active for the first N ticks of the frame.
  - duty 255: active all 256 ticks (full-on special case).
- First frame after reset: shadows are 0, so outputs stay inactive for 256*PRESCALE cycles. The first real duty takes effect at the first frame_start.
- en = 0:
  - pre_cnt, phase and shadows hold.
  - pwm_x goes to the inactive level (INVERT) on the next edge; frame_start stays 0.
  - On en returning to 1, counting resumes from the held pre_cnt and phase. The frame is stretched by the disabled cycles, not restarted.
- All three channels share pre_cnt and phase, so pulses are left-aligned and start together.

Decomposition:
- Shared package rgb_pkg:
  - DUTY_W = 8
  - typedef duty_t = logic [DUTY_W-1:0]
  - typedef rgb_t = packed struct {duty_t r, g, b}
  - This package is reused by the encoder top level and the mixer top.
- Sub-module pwm_channel, instantiated 3x, contains:
  - the shadow register and load enable
  - the compare including the 255 special case
  - the INVERT/en output register
- rgb_pwm itself holds the prescaler, phase counter and frame_start logic.

Test Plan:
- Reset, PRESCALE = 1, duty_r = 64 constant -> pwm_r low for cycles 0..255. frame_start pulses at cycle 256. pwm_r is then high exactly 64 cycles and low 192 cycles, repeating every 256.
- duty_g = 0, duty_b = 255 -> pwm_g never high. pwm_b continuously high from the first frame_start onward, with no low cycle across the frame wrap.
- duty_r = 64 steady, changed to 200 at phase 100 of a frame -> that frame stays high 64 cycles. The next frame is high 200 cycles.
- PRESCALE = 4, duty_r = 10 -> frame_start every 1024 cycles; pwm_r high 40 consecutive cycles per frame.
- PRESCALE = 1, duty_r = 128, en dropped at phase 50 for 37 cycles:
  - outputs inactive from the next edge
  - phase holds at 50
  - on re-enable, pwm_r resumes high
  - that frame's frame_start-to-frame_start spacing is 293 cycles
- INVERT = 1, duty_r = 64 -> pwm_r is the exact complement of the INVERT = 0 waveform. rst asserted mid-frame -> pwm_r = 1 and frame_start = 0 after one edge, then a full 256-cycle inactive first frame.
